// File: rtl/pll_lock_sequencer.sv
// Sequences a PLL's reset and watches its lock output. System reset is released only
// after lock has been stable; repeated acquisition timeouts latch a sticky fault.
module pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int STABLE_CYCLES = 1024,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int MAX_RETRIES   = 3,
  parameter int SYNC_STAGES   = 2,
  localparam int RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1
) (
  input  logic          refclk,
  input  logic          rst,
  input  logic          pll_locked,
  input  logic          clear_fault,
  output logic          pll_rst,
  output logic          sys_rst,
  output logic          ready,
  output logic          fault,
  output logic [RW-1:0] retry_cnt,
  output logic [7:0]    loss_cnt
);

  localparam int M1      = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
  localparam int CNT_MAX = (M1 > LOCK_TIMEOUT) ? M1 : LOCK_TIMEOUT;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(LOCK_TIMEOUT - 1);
  localparam logic [RW-1:0] RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLLRST,
    S_WAIT,
    S_STABLE,
    S_RUN,
    S_FAULT
  } state_t;

  state_t                 state_q;
  logic [CW-1:0]          cnt_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;
  logic                   pll_rst_q;
  logic                   sys_rst_q;
  logic                   ready_q;
  logic                   fault_q;
  logic [RW-1:0]          retry_q;
  logic [7:0]             loss_q;

  // pll_locked comes from the PLL's own domain, so bring it onto refclk first.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign lock_s = sync_q[SYNC_STAGES-1];

  // Outputs are set on the transition edge so they always match the state being entered.
  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q   <= S_PLLRST;
      cnt_q     <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fault_q   <= 1'b0;
      retry_q   <= '0;
      loss_q    <= '0;
    end else begin
      case (state_q)
        S_PLLRST: begin
          if (cnt_q == RST_LAST) begin
            state_q   <= S_WAIT;
            cnt_q     <= '0;
            pll_rst_q <= 1'b0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // Lock takes priority over a timeout landing on the same cycle.
        S_WAIT: begin
          if (lock_s) begin
            state_q <= S_STABLE;
            cnt_q   <= '0;
          end else if (cnt_q == TIMEOUT_LAST) begin
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            if (retry_q < RETRY_LIMIT) begin
              state_q <= S_PLLRST;
              retry_q <= retry_q + RW'(1);
            end else begin
              state_q <= S_FAULT;
              fault_q <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        // A lock drop here is a glitch, not a failed attempt: the retry count is kept.
        S_STABLE: begin
          if (!lock_s) begin
            state_q <= S_WAIT;
            cnt_q   <= '0;
          end else if (cnt_q == STABLE_LAST) begin
            state_q   <= S_RUN;
            cnt_q     <= '0;
            sys_rst_q <= 1'b0;
            ready_q   <= 1'b1;
            retry_q   <= '0;
          end else begin
            cnt_q <= cnt_q + CW'(1);
          end
        end

        S_RUN: begin
          if (!lock_s) begin
            state_q   <= S_PLLRST;
            cnt_q     <= '0;
            pll_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            ready_q   <= 1'b0;
            if (loss_q != 8'hFF) begin
              loss_q <= loss_q + 8'd1;
            end
          end
        end

        S_FAULT: begin
          if (clear_fault) begin
            state_q <= S_PLLRST;
            cnt_q   <= '0;
            fault_q <= 1'b0;
            retry_q <= '0;
          end
        end

        default: begin
          state_q   <= S_PLLRST;
          cnt_q     <= '0;
          pll_rst_q <= 1'b1;
          sys_rst_q <= 1'b1;
          ready_q   <= 1'b0;
        end
      endcase
    end
  end

  assign pll_rst   = pll_rst_q;
  assign sys_rst   = sys_rst_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign retry_cnt = retry_q;
  assign loss_cnt  = loss_q;

endmodule
